peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/peak_detector.sv | 135 +++++++++++++
 tb/tb_peak_detector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/peak_detector.sv
// Threshold-triggered peak finder with holdoff and a one-deep output register.
// Optional pile-up rejection: define PEAK_PILEUP_REJECT_EN.
module peak_detector #(
  parameter int THRESHOLD        = 100,
  parameter int HOLDOFF          = 8,
  parameter int TS_WIDTH         = 32,
  parameter int SIZE_FILTER_DATA = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE_FILTER_DATA:0] input_data,
  input  logic                          peak_ready,
  output logic                          peak_valid,
  output logic signed [SIZE_FILTER_DATA:0] peak_data,
  output logic [TS_WIDTH-1:0]           peak_time,
  output logic [7:0]                    lost_count,
  output logic [7:0]                    pileup_count
);

  localparam int W = SIZE_FILTER_DATA + 1;
  localparam logic signed [W-1:0] THR = W'(THRESHOLD);
  localparam logic [7:0] HOLD_LD = 8'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

  state_t                state;
  logic [TS_WIDTH-1:0]   ts;
  logic [TS_WIDTH-1:0]   max_time;
  logic signed [W-1:0]   max_val;
  logic [7:0]            hold_cnt;

  logic above;
  logic rise_end;
  logic reject;
  logic emit;
  logic xfer;

  assign above    = input_data > THR;
  assign rise_end = (state == RISE) && !above;
  assign emit     = rise_end && !reject;
  assign xfer     = peak_valid && peak_ready;

`ifdef PEAK_PILEUP_REJECT_EN
  logic signed [W-1:0] prev;
  logic                falling;
  logic                pileup;

  // A dip followed by a new rise inside one event means two overlapping pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev         <= '0;
      falling      <= 1'b0;
      pileup       <= 1'b0;
      pileup_count <= '0;
    end else begin
      if (state == IDLE && above) begin
        prev    <= input_data;
        falling <= 1'b0;
        pileup  <= 1'b0;
      end else if (state == RISE) begin
        prev <= input_data;
        if (input_data < prev)
          falling <= 1'b1;
        if (falling && input_data > prev)
          pileup <= 1'b1;
      end
      if (rise_end && reject && pileup_count != 8'hff)
        pileup_count <= pileup_count + 8'd1;
    end
  end

  assign reject = pileup;
`else
  assign reject       = 1'b0;
  assign pileup_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ts       <= '0;
      hold_cnt <= '0;
      max_val  <= '0;
      max_time <= '0;
    end else begin
      ts <= ts + 1'b1;
      case (state)
        IDLE: begin
          if (above) begin
            state    <= RISE;
            max_val  <= input_data;
            max_time <= ts;
          end
        end
        RISE: begin
          if (!above) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LD;
          end else if (input_data > max_val) begin
            max_val  <= input_data;
            max_time <= ts;
          end
        end
        HOLD: begin
          if (hold_cnt != 8'd0)
            hold_cnt <= hold_cnt - 8'd1;
          else if (!above)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A transfer in the same cycle frees the register for the new event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_valid <= 1'b0;
      peak_data  <= '0;
      peak_time  <= '0;
      lost_count <= '0;
    end else if (emit) begin
      if (!peak_valid || peak_ready) begin
        peak_valid <= 1'b1;
        peak_data  <= max_val;
        peak_time  <= max_time;
      end else if (lost_count != 8'hff) begin
        lost_count <= lost_count + 8'd1;
      end
    end else if (xfer) begin
      peak_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_detector.sv
// Directed table plus hand sequences for peak_detector (THRESHOLD=100, HOLDOFF=8).
// Expectations follow PEAK_PILEUP_REJECT_EN when it is defined.
module tb_peak_detector;

  localparam int N = 104;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [15:0] input_data;
  logic              peak_ready;
  logic              peak_valid;
  logic signed [15:0] peak_data;
  logic [7:0]        peak_time;
  logic [7:0]        lost_count;
  logic [7:0]        pileup_count;
  logic [7:0]        tb_ts;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int din;
    bit rdy;
    bit v;
    int d;
    int t;
    int lost;
    int pile;
  } vec_t;

  vec_t vec[N];

  peak_detector #(
    .THRESHOLD(100),
    .HOLDOFF(8),
    .TS_WIDTH(8),
    .SIZE_FILTER_DATA(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_data(input_data),
    .peak_ready(peak_ready),
    .peak_valid(peak_valid),
    .peak_data(peak_data),
    .peak_time(peak_time),
    .lost_count(lost_count),
    .pileup_count(pileup_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset) tb_ts <= 8'd0;
    else tb_ts <= tb_ts + 8'd1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int v);
    input_data = 16'(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pv(input int i, input int v);
    vec[i].din = v;
  endtask

  task automatic ev(input int lo, input int hi, input int d, input int t);
    for (int i = lo; i <= hi; i++) begin
      vec[i].v = 1'b1;
      vec[i].d = d;
      vec[i].t = t;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, int'(peak_valid), 0);
    chk({tag, "_data"}, int'(peak_data), 0);
    chk({tag, "_time"}, int'(peak_time), 0);
    chk({tag, "_lost"}, int'(lost_count), 0);
    chk({tag, "_pile"}, int'(pileup_count), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      vec[i] = '{din: 0, rdy: 1'b1, v: 1'b0, d: 0, t: 0,
                 lost: (i >= 57) ? 1 : 0, pile: 0};
`ifdef PEAK_PILEUP_REJECT_EN
      if (i >= 94) vec[i].pile = 1;
`endif
    end
    // Basic pulse, ignored pulse in holdoff, plateau
    pv(11, 50); pv(12, 150); pv(13, 300); pv(14, 200); pv(15, 90);
    pv(18, 200); pv(19, 200);
    pv(27, 150); pv(28, 250); pv(29, 250); pv(30, 250); pv(31, 50);
    // Back-pressure: A held, B lost
    pv(42, 150); pv(43, 300); pv(44, 100);
    pv(55, 200); pv(56, 500); pv(57, 0);
    // Load in the same cycle as a transfer
    pv(67, 200); pv(78, 400);
    // Pile-up candidate
    pv(90, 150); pv(91, 300); pv(92, 200); pv(93, 400); pv(94, 50);
    for (int i = 44; i <= 57; i++) vec[i].rdy = 1'b0;
    for (int i = 68; i <= 78; i++) vec[i].rdy = 1'b0;
    ev(15, 15, 300, 13);
    ev(31, 31, 250, 28);
    ev(44, 57, 300, 43);
    ev(68, 78, 200, 67);
    ev(79, 79, 400, 78);
`ifndef PEAK_PILEUP_REJECT_EN
    ev(94, 94, 400, 93);
`endif

    reset = 1'b0;
    peak_ready = 1'b1;
    input_data = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_reset("por");

    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      peak_ready = vec[i].rdy;
      step(vec[i].din);
      chk($sformatf("valid@%0d", i), int'(peak_valid), int'(vec[i].v));
      chk($sformatf("lost@%0d", i), int'(lost_count), vec[i].lost);
      chk($sformatf("pile@%0d", i), int'(pileup_count), vec[i].pile);
      if (vec[i].v) begin
        chk($sformatf("data@%0d", i), int'(peak_data), vec[i].d);
        chk($sformatf("time@%0d", i), int'(peak_time), vec[i].t);
      end
    end

    // Reset while in RISE
    peak_ready = 1'b1;
    step(200);
    reset = 1'b0;
    step(0);
    chk_reset("rst_rise");
    reset = 1'b1;
    step(150);
    step(300);
    step(0);
    chk("post_rst_valid", int'(peak_valid), 1);
    chk("post_rst_data", int'(peak_data), 300);
    chk("post_rst_time", int'(peak_time), 1);

    // Reset with an event pending
    peak_ready = 1'b0;
    step(0);
    chk("pend_valid", int'(peak_valid), 1);
    reset = 1'b0;
    step(0);
    chk_reset("rst_pend");
    reset = 1'b1;
    peak_ready = 1'b1;

    // Timestamp wrap inside a pulse
    for (int k = 0; k < 300 && tb_ts != 8'd254; k++)
      step(0);
    chk("wrap_start", int'(tb_ts), 254);
    step(150);
    step(200);
    step(300);
    step(400);
    step(0);
    chk("wrap_valid", int'(peak_valid), 1);
    chk("wrap_data", int'(peak_data), 400);
    chk("wrap_time", int'(peak_time), 1);
    step(0);
    chk("wrap_clear", int'(peak_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
